// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, EX-driven redirects and the IF/ID pipeline register.
// Optional IF_PERF_CNT_EN adds fetch/stall/flush event counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [1:0]  ex_npc_op,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_alu_c,
    output logic [31:0] irom_addr,
    input  logic [31:0] irom_inst,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        redirect
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    localparam int unsigned XLEN = 32;
    localparam logic [1:0] NPC_SEQ  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JALR = 2'd2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pc4_q, id_pc4_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;

`ifdef IF_PERF_CNT_EN
    logic [XLEN-1:0] perf_fetch_q, perf_fetch_d;
    logic [XLEN-1:0] perf_stall_q, perf_stall_d;
    logic [XLEN-1:0] perf_flush_q, perf_flush_d;
`endif

    // Redirect decision and target; op 3 is treated as sequential
    always_comb begin
        redirect = 1'b0;
        target   = ex_pc + ex_imm;
        if (ex_valid && (ex_npc_op == NPC_BR || ex_npc_op == NPC_JALR)) begin
            redirect = 1'b1;
        end
        if (ex_npc_op == NPC_JALR) begin
            target = ex_alu_c & ~XLEN'(1);
        end
    end

    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-state: redirect > stall > normal
    always_comb begin
        pc_d       = pc_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
`ifdef IF_PERF_CNT_EN
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
`endif
        if (redirect) begin
            pc_d       = target;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
`ifdef IF_PERF_CNT_EN
            perf_flush_d = perf_flush_q + XLEN'(1);
`endif
        end else if (stall) begin
`ifdef IF_PERF_CNT_EN
            perf_stall_d = perf_stall_q + XLEN'(1);
`endif
        end else begin
            pc_d       = pc_plus4;
            id_inst_d  = irom_inst;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
`ifdef IF_PERF_CNT_EN
            perf_fetch_d = perf_fetch_q + XLEN'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            id_inst_q  <= NOP_INST;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
`ifdef IF_PERF_CNT_EN
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
`endif
        end else begin
            pc_q       <= pc_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
`ifdef IF_PERF_CNT_EN
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
`endif
        end
    end

    assign irom_addr = pc_q;
    assign id_inst   = id_inst_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc4_q;
    assign id_valid  = id_valid_q;
`ifdef IF_PERF_CNT_EN
    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; ROM returns addr ^ 32'hDEAD_0000.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic [1:0]  ex_npc_op;
    logic [31:0] ex_pc, ex_imm, ex_alu_c;
    logic [31:0] irom_addr, irom_inst;
    logic [31:0] id_inst, id_pc, id_pc4;
    logic        id_valid, redirect;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign irom_inst = irom_addr ^ 32'hDEAD_0000;

    if_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .ex_valid  (ex_valid),
        .ex_npc_op (ex_npc_op),
        .ex_pc     (ex_pc),
        .ex_imm    (ex_imm),
        .ex_alu_c  (ex_alu_c),
        .irom_addr (irom_addr),
        .irom_inst (irom_inst),
        .id_inst   (id_inst),
        .id_pc     (id_pc),
        .id_pc4    (id_pc4),
        .id_valid  (id_valid),
        .redirect  (redirect)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch(perf_fetch),
        .perf_stall(perf_stall),
        .perf_flush(perf_flush)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ex_set(input logic v, input logic [1:0] op, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] alu);
        ex_valid  = v;
        ex_npc_op = op;
        ex_pc     = pc;
        ex_imm    = imm;
        ex_alu_c  = alu;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic v);
        chk({tag, ".inst"}, id_inst, inst);
        chk({tag, ".pc"}, id_pc, pc);
        chk({tag, ".pc4"}, id_pc4, pc4);
        chk({tag, ".valid"}, 32'(id_valid), 32'(v));
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        ex_set(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst.addr", irom_addr, 32'h0);
        chk_ifid("rst", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;

        // Sequential fetch from reset
        step();
        chk("seq1.addr", irom_addr, 32'h4);
        chk_ifid("seq1", 32'hDEAD_0000, 32'h0, 32'h4, 1'b1);
        step();
        chk("seq2.addr", irom_addr, 32'h8);
        chk_ifid("seq2", 32'hDEAD_0004, 32'h4, 32'h8, 1'b1);
        step();
        chk("seq3.addr", irom_addr, 32'hC);
        chk_ifid("seq3", 32'hDEAD_0008, 32'h8, 32'hC, 1'b1);
        step();
        chk("seq4.addr", irom_addr, 32'h10);

        // Backward branch 0x08 + (-8) = 0x0
        ex_set(1'b1, 2'd1, 32'h8, 32'hFFFF_FFF8, 32'h0);
        #1 chk("br.redirect", 32'(redirect), 32'd1);
        step();
        ex_set(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        chk("br.addr", irom_addr, 32'h0);
        chk_ifid("br", 32'h0000_0013, 32'hC, 32'h10, 1'b0);

        // jalr clears bit 0
        ex_set(1'b1, 2'd2, 32'h0, 32'h0, 32'h0000_0123);
        #1 chk("jalr.redirect", 32'(redirect), 32'd1);
        step();
        chk("jalr.addr", irom_addr, 32'h122);
        ex_set(1'b0, 2'd2, 32'h0, 32'h0, 32'h0000_0123);
        #1 chk("jalr_inv.redirect", 32'(redirect), 32'd0);
        step();
        chk("jalr_inv.addr", irom_addr, 32'h126);
        chk_ifid("jalr_inv", 32'hDEAD_0122, 32'h122, 32'h126, 1'b1);

        // Reserved op 3 behaves as sequential
        ex_set(1'b1, 2'd3, 32'h500, 32'h500, 32'h500);
        #1 chk("op3.redirect", 32'(redirect), 32'd0);
        step();
        chk("op3.addr", irom_addr, 32'h12A);

        // Redirect to 0x1C, fetch once, then stall three cycles at 0x20
        ex_set(1'b1, 2'd1, 32'h1C, 32'h0, 32'h0);
        step();
        ex_set(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        step();
        chk("pre_stall.addr", irom_addr, 32'h20);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d.addr", i), irom_addr, 32'h20);
            chk_ifid($sformatf("stall%0d", i), 32'hDEAD_001C, 32'h1C, 32'h20, 1'b1);
        end
        ex_set(1'b1, 2'd1, 32'h40, 32'h0, 32'h0);
        #1 chk("stall_br.redirect", 32'(redirect), 32'd1);
        step();
        stall = 1'b0;
        ex_set(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        chk("stall_br.addr", irom_addr, 32'h40);
        chk_ifid("stall_br", 32'h0000_0013, 32'h1C, 32'h20, 1'b0);

        // PC wrap via jalr to 0xFFFF_FFFD -> 0xFFFF_FFFC
        ex_set(1'b1, 2'd2, 32'h0, 32'h0, 32'hFFFF_FFFD);
        step();
        ex_set(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        chk("wrap0.addr", irom_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap1.addr", irom_addr, 32'h0);
        chk_ifid("wrap1", 32'h2152_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);

        // Misaligned branch target passes through
        ex_set(1'b1, 2'd1, 32'h100, 32'h2, 32'h0);
        step();
        ex_set(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        chk("mis.addr", irom_addr, 32'h102);
        step();
        chk("mis2.addr", irom_addr, 32'h106);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst.addr", irom_addr, 32'h0);
        chk_ifid("arst", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("arst.pf", perf_fetch, 32'h0);
        chk("arst.ps", perf_stall, 32'h0);
        chk("arst.pl", perf_flush, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst.addr", irom_addr, 32'h4);
        chk_ifid("post_rst", 32'hDEAD_0000, 32'h0, 32'h4, 1'b1);

        // 5 normal, 2 stall, 1 redirect edges since reset
        for (int i = 0; i < 4; i++) step();
        stall = 1'b1;
        step();
        step();
        ex_set(1'b1, 2'd1, 32'h80, 32'h0, 32'h0);
        step();
        stall = 1'b0;
        ex_set(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        chk("perf_seq.addr", irom_addr, 32'h80);
`ifdef IF_PERF_CNT_EN
        chk("perf.fetch", perf_fetch, 32'd5);
        chk("perf.stall", perf_stall, 32'd2);
        chk("perf.flush", perf_flush, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
